// File: rtl/sid_bus_regs.sv
// rtl/sid_bus_regs.sv - SID bus-side register file with read mux and data-bus capacitor decay

package sid;
    typedef enum logic {
        MOS6581 = 1'b0,
        MOS8580 = 1'b1
    } model_e;

    // One-hot SID cycle phase; bit positions below.
    typedef logic [3:0] phase_t;
    localparam int PHI1      = 0;
    localparam int PHI1_PHI2 = 1;
    localparam int PHI2      = 2;
    localparam int PHI2_PHI1 = 3;
endpackage

module sid_bus_regs #(
    parameter logic [13:0] BUS_TTL_6581 = 14'd8,
    parameter logic [13:0] BUS_TTL_8580 = 14'd664
) (
    input  logic              clk,
    input  logic              res,
    input  logic              tick_ms,
    input  sid::model_e       model,
    input  sid::phase_t       phase,
    input  logic              bus_cs,
    input  logic              bus_rw,
    input  logic [4:0]        bus_addr,
    input  logic [7:0]        bus_data_i,
    input  logic [7:0]        potx,
    input  logic [7:0]        poty,
    input  logic [7:0]        osc3,
    input  logic [7:0]        env3,
    output logic [24:0][7:0]  regs_o,
    output logic [7:0]        bus_data_o
);

    localparam logic [4:0] LAST_RW_ADDR = 5'h18;

    logic [24:0][7:0] regs_q, regs_d;
    logic [7:0]       bus_value_q, bus_value_d;
    logic [13:0]      bus_age_q, bus_age_d;
    logic [7:0]       rdata_q, rdata_d;

    logic             access;
    logic [13:0]      ttl;
    logic [7:0]       rd_value;

    assign access = phase[sid::PHI2_PHI1] && bus_cs;
    assign ttl    = (model == sid::MOS6581) ? BUS_TTL_6581 : BUS_TTL_8580;

    // Write-only and unused addresses return whatever the bus capacitor still holds.
    always_comb begin
        rd_value = bus_value_q;
        case (bus_addr)
            5'h19:   rd_value = potx;
            5'h1A:   rd_value = poty;
            5'h1B:   rd_value = osc3;
            5'h1C:   rd_value = env3;
            default: rd_value = bus_value_q;
        endcase
    end

    always_comb begin
        regs_d      = regs_q;
        bus_value_d = bus_value_q;
        bus_age_d   = bus_age_q;
        rdata_d     = rdata_q;
        if (access) begin
            bus_age_d = 14'd0;
            if (!bus_rw) begin
                if (bus_addr <= LAST_RW_ADDR) begin
                    regs_d[bus_addr] = bus_data_i;
                end
                bus_value_d = bus_data_i;
            end else begin
                rdata_d     = rd_value;
                bus_value_d = rd_value;
            end
        end else if (bus_age_q >= ttl) begin
            // >= so that a switch to a shorter TTL past the current age still expires.
            bus_value_d = 8'h00;
        end else begin
            bus_age_d = bus_age_q + {13'd0, tick_ms};
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            regs_q      <= '0;
            bus_value_q <= 8'h00;
            bus_age_q   <= 14'd0;
            rdata_q     <= 8'h00;
        end else begin
            regs_q      <= regs_d;
            bus_value_q <= bus_value_d;
            bus_age_q   <= bus_age_d;
            rdata_q     <= rdata_d;
        end
    end

    assign regs_o     = regs_q;
    assign bus_data_o = rdata_q;

endmodule

// File: tb/tb_sid_bus_regs.sv
// tb/tb_sid_bus_regs.sv - directed self-checking bench for sid_bus_regs

module tb_sid_bus_regs;

    logic             clk;
    logic             res;
    logic             tick_ms;
    sid::model_e      model;
    sid::phase_t      phase;
    logic             bus_cs;
    logic             bus_rw;
    logic [4:0]       bus_addr;
    logic [7:0]       bus_data_i;
    logic [7:0]       potx, poty, osc3, env3;
    logic [24:0][7:0] regs_o;
    logic [7:0]       bus_data_o;

    logic [24:0][7:0] er;
    int               total;
    int               bad;

    sid_bus_regs dut (
        .clk        (clk),
        .res        (res),
        .tick_ms    (tick_ms),
        .model      (model),
        .phase      (phase),
        .bus_cs     (bus_cs),
        .bus_rw     (bus_rw),
        .bus_addr   (bus_addr),
        .bus_data_i (bus_data_i),
        .potx       (potx),
        .poty       (poty),
        .osc3       (osc3),
        .env3       (env3),
        .regs_o     (regs_o),
        .bus_data_o (bus_data_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; the access occupies exactly one rising edge.
    task automatic acc(input logic rw, input logic [4:0] a, input logic [7:0] d);
        phase      = 4'b1000;
        bus_cs     = 1'b1;
        bus_rw     = rw;
        bus_addr   = a;
        bus_data_i = d;
        @(negedge clk);
        bus_cs = 1'b0;
        phase  = 4'b0001;
        if (!rw && a <= 5'h18 && !res) er[a] = d;
    endtask

    task automatic ticks(input int n);
        tick_ms = 1'b1;
        repeat (n) @(negedge clk);
        tick_ms = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        er         = '0;
        res        = 1'b1;
        tick_ms    = 1'b0;
        model      = sid::MOS6581;
        phase      = 4'b0001;
        bus_cs     = 1'b0;
        bus_rw     = 1'b1;
        bus_addr   = 5'h00;
        bus_data_i = 8'h00;
        potx       = 8'h12;
        poty       = 8'h34;
        osc3       = 8'h7E;
        env3       = 8'hC3;
        idle(2);
        res = 1'b0;
        check("reset_regs", 200'(regs_o), 200'(0));
        check("reset_rdata", 200'(bus_data_o), 200'h00);

        acc(1'b0, 5'h04, 8'h41);
        check("wr04_reg4", 200'(regs_o[4]), 200'h41);
        check("wr04_all", 200'(regs_o), 200'(er));
        check("wr04_rdata", 200'(bus_data_o), 200'h00);

        acc(1'b0, 5'h00, 8'hA5);
        idle(10);
        acc(1'b1, 5'h00, 8'h00);
        check("rd00_busval", 200'(bus_data_o), 200'hA5);
        ticks(9);
        acc(1'b1, 5'h05, 8'h00);
        check("rd05_decayed", 200'(bus_data_o), 200'h00);

        acc(1'b0, 5'h06, 8'h3C);
        ticks(7);
        idle(3);
        acc(1'b1, 5'h1D, 8'h00);
        check("rd1d_age7", 200'(bus_data_o), 200'h3C);

        acc(1'b0, 5'h07, 8'h5A);
        ticks(8);
        acc(1'b1, 5'h1D, 8'h00);
        check("rd_at_expiry", 200'(bus_data_o), 200'h5A);

        acc(1'b1, 5'h1B, 8'h00);
        check("rd_osc3", 200'(bus_data_o), 200'h7E);
        acc(1'b1, 5'h1C, 8'h00);
        check("rd_env3", 200'(bus_data_o), 200'hC3);
        acc(1'b1, 5'h1E, 8'h00);
        check("rd1e_refresh", 200'(bus_data_o), 200'hC3);
        acc(1'b1, 5'h19, 8'h00);
        check("rd_potx", 200'(bus_data_o), 200'h12);
        acc(1'b1, 5'h1A, 8'h00);
        check("rd_poty", 200'(bus_data_o), 200'h34);
        acc(1'b0, 5'h03, 8'h11);
        check("wr_keeps_rdata", 200'(bus_data_o), 200'h34);
        acc(1'b0, 5'h19, 8'hEE);
        check("wr19_regs", 200'(regs_o), 200'(er));

        model = sid::MOS8580;
        acc(1'b0, 5'h18, 8'h0F);
        check("wr18_reg24", 200'(regs_o[24]), 200'h0F);
        ticks(663);
        acc(1'b1, 5'h1F, 8'h00);
        check("rd1f_663", 200'(bus_data_o), 200'h0F);
        acc(1'b0, 5'h18, 8'h0F);
        ticks(665);
        acc(1'b1, 5'h1F, 8'h00);
        check("rd1f_665", 200'(bus_data_o), 200'h00);

        acc(1'b0, 5'h10, 8'h99);
        ticks(20);
        model = sid::MOS6581;
        idle(1);
        acc(1'b1, 5'h1D, 8'h00);
        check("model_switch_exp", 200'(bus_data_o), 200'h00);

        acc(1'b0, 5'h1F, 8'h22);
        for (int p = 0; p < 3; p++) begin
            phase      = 4'(1 << p);
            bus_cs     = 1'b1;
            bus_rw     = 1'b0;
            bus_addr   = 5'h01;
            bus_data_i = 8'hFF;
            @(negedge clk);
        end
        bus_cs = 1'b0;
        check("offphase_reg1", 200'(regs_o[1]), 200'h00);
        acc(1'b1, 5'h1D, 8'h00);
        check("offphase_busval", 200'(bus_data_o), 200'h22);
        acc(1'b0, 5'h01, 8'hFF);
        check("onphase_reg1", 200'(regs_o[1]), 200'hFF);

        res = 1'b1;
        acc(1'b0, 5'h02, 8'h55);
        res = 1'b0;
        er  = '0;
        check("res_wr_reg2", 200'(regs_o[2]), 200'h00);
        check("res_wr_all", 200'(regs_o), 200'(er));
        check("res_rdata", 200'(bus_data_o), 200'h00);
        acc(1'b1, 5'h02, 8'h00);
        check("res_rd02", 200'(bus_data_o), 200'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
